mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, the byte address width.
REQ-002 SHALL have parameter LINE_W, default 1024, the cache line width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port b_addr_i  input  ADDR_W  instruction-port line address.
REQ-006 SHALL have port b_rd_i  input  1  instruction read request, level, held until b_dv_i is seen.
REQ-007 SHALL have port b_data_i  output  LINE_W  instruction read line.
REQ-008 SHALL have port b_dv_i  output  1  instruction data valid, 1-cycle pulse.
REQ-009 SHALL have port b_addr  input  ADDR_W  data-port line address.
REQ-010 SHALL have port b_rd  input  1  data read request, level, held until b_dv is seen.
REQ-011 SHALL have port b_data_in  output  LINE_W  data read line.
REQ-012 SHALL have port b_dv  output  1  data read valid, 1-cycle pulse.
REQ-013 SHALL have port b_wr  input  1  data write strobe, 1-cycle.
REQ-014 SHALL have port b_data_out  input  LINE_W  data write line.
REQ-015 SHALL have port b_wr_rdy  output  1  write buffer empty; write accepted when b_wr and b_wr_rdy.
REQ-016 SHALL have ports m_addr  output  ADDR_W,  m_rd  output  1,  m_wr  output  1,  m_data_out  output  LINE_W: downstream memory request.
REQ-017 SHALL have ports m_data_in  input  LINE_W,  m_dv  input  1: memory read data/write ack, 1-cycle pulse.

Function
REQ-018 SHALL implement FSM states IDLE, RD_I, RD_D, WR, RESP.
REQ-019 SHALL hold a one-entry write buffer (address, line, valid); b_wr_rdy = !valid, combinational.
REQ-020 SHALL capture b_addr/b_data_out into the buffer and set valid on an edge where b_wr && b_wr_rdy; b_wr with !b_wr_rdy is dropped.
REQ-021 IDLE grant priority SHALL be: buffered write, then reads; on an edge where a write is being accepted, no read is granted.
REQ-022 When b_rd_i and b_rd both pending in IDLE, grant SHALL alternate, starting with data after reset (last-grant bit).
REQ-023 On grant, SHALL register m_addr (and m_data_out for WR), pulse m_rd or m_wr for exactly one cycle, enter RD_I/RD_D/WR.
REQ-024 m_addr and m_data_out SHALL stay stable from grant until the m_dv edge.
REQ-025 In RD_I/RD_D on m_dv, SHALL register m_data_in into b_data_i/b_data_in, pulse b_dv_i/b_dv one cycle, enter RESP.
REQ-026 RESP SHALL last exactly one cycle then go IDLE, so a request dropped after dv is not re-issued.
REQ-027 In WR on m_dv, SHALL clear buffer valid and go IDLE; no requester pulse.
REQ-028 m_dv in IDLE or RESP SHALL be ignored.
REQ-029 b_data_i/b_data_in SHALL hold the last returned line until the next respective dv.
REQ-030 Latency: request sampled in IDLE at edge N -> m_rd high in cycle N..N+1; memory m_dv at edge M -> b_dv high in cycle after M.
REQ-031 Address SHALL pass unmodified; no translation or alignment.

Reset
REQ-032 On rst, SHALL set state IDLE, last-grant to instruction (so data wins first), buffer valid 0.
REQ-033 On rst, m_rd, m_wr, b_dv_i, b_dv SHALL be 0; m_addr, m_data_out, b_data_i, b_data_in 0; b_wr_rdy 1 the cycle after.
REQ-034 Reset mid-transaction SHALL abandon it; a later m_dv is ignored per REQ-028.

Verification
REQ-035 b_rd_i=1, b_addr_i=0x80000000, memory m_dv 4 cycles after m_rd -> one m_rd pulse at 0x80000000, b_dv_i one cycle after m_dv, b_data_i=m_data_in.
REQ-036 b_rd_i and b_rd both held, addrs 0x80000000/0x100 -> m_addr order 0x100, 0x80000000, each answered to correct port.
REQ-037 b_wr addr 0x200 line L, same cycle b_rd addr 0x200 -> m_wr at 0x200 with L first, then m_rd 0x200; b_wr_rdy 0 until write m_dv.
REQ-038 second b_wr while buffer full -> dropped, only first line written.
REQ-039 request held through b_dv then dropped -> exactly one m_rd, RESP cycle observed.
REQ-040 rst asserted in RD_D before m_dv -> outputs zero, later m_dv produces no b_dv.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port line-read arbiter with a one-entry posted write buffer in front of a single memory port.
// Reads alternate between instruction and data when both are pending; buffered writes go first.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic              b_rd_i,
  output logic [LINE_W-1:0] b_data_i,
  output logic              b_dv_i,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_rd,
  output logic [LINE_W-1:0] b_data_in,
  output logic              b_dv,
  input  logic              b_wr,
  input  logic [LINE_W-1:0] b_data_out,
  output logic              b_wr_rdy,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [LINE_W-1:0] m_data_out,
  input  logic [LINE_W-1:0] m_data_in,
  input  logic              m_dv
);

  typedef enum logic [2:0] {StIdle, StRdI, StRdD, StWr, StResp} state_e;

  state_e              state_q, state_d;
  logic                wbuf_valid_q, wbuf_valid_d;
  logic [ADDR_W-1:0]   wbuf_addr_q, wbuf_addr_d;
  logic [LINE_W-1:0]   wbuf_line_q, wbuf_line_d;
  logic                last_data_q, last_data_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [LINE_W-1:0]   m_data_out_q, m_data_out_d;
  logic                m_rd_q, m_rd_d;
  logic                m_wr_q, m_wr_d;
  logic [LINE_W-1:0]   b_data_i_q, b_data_i_d;
  logic [LINE_W-1:0]   b_data_in_q, b_data_in_d;
  logic                b_dv_i_q, b_dv_i_d;
  logic                b_dv_q, b_dv_d;

  logic wr_accept;
  logic grant_d;

  assign wr_accept = b_wr & ~wbuf_valid_q;
  // Data wins unless it was the last read granted and instruction is also waiting.
  assign grant_d   = b_rd & (~b_rd_i | ~last_data_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wbuf_valid_q <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_line_q  <= '0;
      last_data_q  <= 1'b0;
      m_addr_q     <= '0;
      m_data_out_q <= '0;
      m_rd_q       <= 1'b0;
      m_wr_q       <= 1'b0;
      b_data_i_q   <= '0;
      b_data_in_q  <= '0;
      b_dv_i_q     <= 1'b0;
      b_dv_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_line_q  <= wbuf_line_d;
      last_data_q  <= last_data_d;
      m_addr_q     <= m_addr_d;
      m_data_out_q <= m_data_out_d;
      m_rd_q       <= m_rd_d;
      m_wr_q       <= m_wr_d;
      b_data_i_q   <= b_data_i_d;
      b_data_in_q  <= b_data_in_d;
      b_dv_i_q     <= b_dv_i_d;
      b_dv_q       <= b_dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wbuf_valid_q) begin
          state_d = StWr;
        end else if (!wr_accept) begin
          if (grant_d) begin
            state_d = StRdD;
          end else if (b_rd_i) begin
            state_d = StRdI;
          end
        end
      end
      StRdI, StRdD: if (m_dv) state_d = StResp;
      StWr:         if (m_dv) state_d = StIdle;
      StResp:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    wbuf_valid_d = wbuf_valid_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_line_d  = wbuf_line_q;
    last_data_d  = last_data_q;
    m_addr_d     = m_addr_q;
    m_data_out_d = m_data_out_q;
    m_rd_d       = 1'b0;
    m_wr_d       = 1'b0;
    b_data_i_d   = b_data_i_q;
    b_data_in_d  = b_data_in_q;
    b_dv_i_d     = 1'b0;
    b_dv_d       = 1'b0;

    if (wr_accept) begin
      wbuf_valid_d = 1'b1;
      wbuf_addr_d  = b_addr;
      wbuf_line_d  = b_data_out;
    end

    unique case (state_q)
      StIdle: begin
        if (state_d == StWr) begin
          m_addr_d     = wbuf_addr_q;
          m_data_out_d = wbuf_line_q;
          m_wr_d       = 1'b1;
        end else if (state_d == StRdD) begin
          m_addr_d    = b_addr;
          m_rd_d      = 1'b1;
          last_data_d = 1'b1;
        end else if (state_d == StRdI) begin
          m_addr_d    = b_addr_i;
          m_rd_d      = 1'b1;
          last_data_d = 1'b0;
        end
      end
      StRdI: begin
        if (m_dv) begin
          b_data_i_d = m_data_in;
          b_dv_i_d   = 1'b1;
        end
      end
      StRdD: begin
        if (m_dv) begin
          b_data_in_d = m_data_in;
          b_dv_d      = 1'b1;
        end
      end
      StWr: begin
        if (m_dv) wbuf_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign b_wr_rdy   = ~wbuf_valid_q;
  assign m_addr     = m_addr_q;
  assign m_data_out = m_data_out_q;
  assign m_rd       = m_rd_q;
  assign m_wr       = m_wr_q;
  assign b_data_i   = b_data_i_q;
  assign b_data_in  = b_data_in_q;
  assign b_dv_i     = b_dv_i_q;
  assign b_dv       = b_dv_q;

endmodule
